// File: rtl/router_pkg.sv
// Shared definitions for the router configuration sequencer: FSM encoding,
// default replay timing and a constant-friendly clog2.
package router_pkg;

  localparam int unsigned T_SETUP_DEF = 2;
  localparam int unsigned T_PULSE_DEF = 2;
  localparam int unsigned T_HOLD_DEF  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_SETUP = 3'd2,
    ST_PULSE = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Lowest-set-bit encoder: index of the least significant request plus any-valid.
module prio_enc_n
  import router_pkg::*;
#(
  parameter int unsigned N_OUT = 8,
  parameter int unsigned W_IDX = (clog2(N_OUT) > 0) ? clog2(N_OUT) : 1
) (
  input  logic [N_OUT-1:0] req,
  output logic [W_IDX-1:0] idx,
  output logic             valid
);

  // Scan from the top so the lowest set bit is written last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = N_OUT; i > 0; i--) begin
      if (req[i-1]) begin
        idx   = W_IDX'(i - 1);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_cfg_seq.sv
// Configuration sequencer: shadows front-panel route writes and, on commit,
// replays each dirty destination to the router with setup/pulse/hold timing.
module router_cfg_seq
  import router_pkg::*;
#(
  parameter int unsigned W_SEL   = 4,
  parameter int unsigned N_IN    = 8,
  parameter int unsigned N_OUT   = 8,
  parameter int unsigned T_SETUP = T_SETUP_DEF,
  parameter int unsigned T_PULSE = T_PULSE_DEF,
  parameter int unsigned T_HOLD  = T_HOLD_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             cfg_wr_in,
  input  logic [W_SEL-1:0] cfg_dest_in,
  input  logic [W_SEL-1:0] cfg_src_in,
  input  logic             cfg_active_in,
  input  logic             cfg_commit_in,
  output logic [W_SEL-1:0] src_select_out,
  output logic [W_SEL-1:0] dest_select_out,
  output logic [N_OUT-1:0] output_active_out,
  output logic             update_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             cfg_err_out
);

  localparam int unsigned IDX_W = (clog2(N_OUT) > 0) ? clog2(N_OUT) : 1;
  localparam int unsigned T_MAX = max3(T_SETUP, T_PULSE, T_HOLD);
  localparam int unsigned CNT_W = clog2(T_MAX + 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;

  logic [W_SEL-1:0] shadow_src [N_OUT];
  logic [N_OUT-1:0] shadow_act;
  logic [N_OUT-1:0] dirty;

  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] scan_idx;
  logic             scan_valid;
  logic             wr_bad;
  logic             wr_ok;
  logic             load_entry;

  logic             update_d;
  logic             busy_d;
  logic             done_d;

  assign wr_bad     = cfg_wr_in && ((32'(cfg_dest_in) >= N_OUT) || (32'(cfg_src_in) >= N_IN));
  assign wr_ok      = cfg_wr_in && !wr_bad;
  assign wr_idx     = IDX_W'(cfg_dest_in);
  assign load_entry = (state == ST_SCAN) && scan_valid;

  prio_enc_n #(
    .N_OUT (N_OUT),
    .W_IDX (IDX_W)
  ) u_prio_enc (
    .req   (dirty),
    .idx   (scan_idx),
    .valid (scan_valid)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cfg_commit_in) state_nxt = ST_SCAN;
      ST_SCAN:  state_nxt = scan_valid ? ST_SETUP : ST_DONE;
      ST_SETUP: if (cnt == '0) state_nxt = ST_PULSE;
      ST_PULSE: if (cnt == '0) state_nxt = ST_HOLD;
      ST_HOLD:  if (cnt == '0) state_nxt = ST_SCAN;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs follow the state being entered, so they align with it.
  always_comb begin
    update_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_nxt)
      ST_SCAN, ST_SETUP, ST_HOLD: busy_d = 1'b1;
      ST_PULSE: begin
        busy_d   = 1'b1;
        update_d = 1'b1;
      end
      ST_DONE:  done_d = 1'b1;
      default:  ;
    endcase
  end

  // One down-counter shared by the timed states, reloaded on every state entry.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      case (state_nxt)
        ST_SETUP: cnt <= CNT_W'(T_SETUP - 1);
        ST_PULSE: cnt <= CNT_W'(T_PULSE - 1);
        ST_HOLD:  cnt <= CNT_W'(T_HOLD - 1);
        default:  cnt <= '0;
      endcase
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Shadow table; a write in the same cycle as the scan clear keeps the entry dirty.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < N_OUT; i++) shadow_src[i] <= '0;
      shadow_act <= '0;
      dirty      <= '1;
    end else begin
      if (load_entry) dirty[scan_idx] <= 1'b0;
      if (wr_ok) begin
        shadow_src[wr_idx] <= cfg_src_in;
        shadow_act[wr_idx] <= cfg_active_in;
        dirty[wr_idx]      <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      src_select_out    <= '0;
      dest_select_out   <= '0;
      output_active_out <= '0;
      update_out        <= 1'b0;
      busy_out          <= 1'b0;
      done_out          <= 1'b0;
      cfg_err_out       <= 1'b0;
    end else begin
      update_out  <= update_d;
      busy_out    <= busy_d;
      done_out    <= done_d;
      cfg_err_out <= wr_bad;
      if (load_entry) begin
        src_select_out    <= shadow_src[scan_idx];
        dest_select_out   <= W_SEL'(scan_idx);
        output_active_out <= shadow_act;
      end
    end
  end

endmodule

// File: tb/tb_router_cfg_seq.sv
// Self-checking bench for router_cfg_seq: randomized writes/commits compared
// against a table-level model of the shadow state and replay order/timing.
module tb_router_cfg_seq;
  import router_pkg::*;

  localparam int unsigned W_SEL  = 4;
  localparam int unsigned N_IN   = 8;
  localparam int unsigned N_OUT  = 8;
  localparam int unsigned T_S    = 2;
  localparam int unsigned T_P    = 2;
  localparam int unsigned T_H    = 2;
  localparam int unsigned PERIOD = 1 + T_S + T_P + T_H;
  localparam int unsigned HW     = 1 + 2 * W_SEL + N_OUT;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_wr = 1'b0;
  logic [W_SEL-1:0] cfg_dest = '0;
  logic [W_SEL-1:0] cfg_src = '0;
  logic             cfg_active = 1'b0;
  logic             cfg_commit = 1'b0;
  logic [W_SEL-1:0] src_sel;
  logic [W_SEL-1:0] dest_sel;
  logic [N_OUT-1:0] act_mask;
  logic             update;
  logic             busy;
  logic             done;
  logic             err;

  router_cfg_seq #(
    .W_SEL(W_SEL), .N_IN(N_IN), .N_OUT(N_OUT),
    .T_SETUP(T_S), .T_PULSE(T_P), .T_HOLD(T_H)
  ) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .cfg_wr_in         (cfg_wr),
    .cfg_dest_in       (cfg_dest),
    .cfg_src_in        (cfg_src),
    .cfg_active_in     (cfg_active),
    .cfg_commit_in     (cfg_commit),
    .src_select_out    (src_sel),
    .dest_select_out   (dest_sel),
    .output_active_out (act_mask),
    .update_out        (update),
    .busy_out          (busy),
    .done_out          (done),
    .cfg_err_out       (err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned rise;
    int unsigned dest;
    int unsigned src;
    int unsigned act;
    bit          ok;
  } pulse_t;

  pulse_t plog[$];
  pulse_t exp_q[$];

  // Pulse monitor: logs each completed update with a setup/pulse/hold stability verdict.
  logic [HW-1:0] hist [PERIOD];
  logic          prev_upd = 1'b0;
  logic          prev_rst = 1'b0;
  int unsigned   hc = 0;
  pulse_t        cur;

  always @(negedge clk) begin
    for (int i = PERIOD - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {update, dest_sel, src_sel, act_mask};
    if (rst || prev_rst) begin
      hc = 0;
    end else begin
      if (update && !prev_upd) begin
        cur.rise = cyc;
        cur.dest = 32'(dest_sel);
        cur.src  = 32'(src_sel);
        cur.act  = 32'(act_mask);
      end
      if (!update && prev_upd) hc = 1;
      else if (hc != 0)        hc++;
      if (hc == T_H) begin
        cur.ok = 1'b1;
        for (int i = 0; i < int'(T_S + T_P + T_H); i++) begin
          if (hist[i][HW-2:0] !== hist[0][HW-2:0]) cur.ok = 1'b0;
          if (hist[i][HW-1] !== ((i >= int'(T_H)) && (i < int'(T_H + T_P)))) cur.ok = 1'b0;
        end
        plog.push_back(cur);
        hc = 0;
      end
    end
    prev_upd = update;
    prev_rst = rst;
  end

  // Reference model: shadow table, activation bits and dirty set.
  int unsigned m_src   [N_OUT];
  bit          m_act   [N_OUT];
  bit          m_dirty [N_OUT];

  function automatic void model_reset();
    for (int d = 0; d < int'(N_OUT); d++) begin
      m_src[d] = 0; m_act[d] = 1'b0; m_dirty[d] = 1'b1;
    end
  endfunction

  function automatic bit model_write(input int unsigned d, input int unsigned s, input bit a);
    if (d >= N_OUT || s >= N_IN) return 1'b1;
    m_src[d] = s; m_act[d] = a; m_dirty[d] = 1'b1;
    return 1'b0;
  endfunction

  function automatic int unsigned model_mask();
    int unsigned m = 0;
    for (int d = 0; d < int'(N_OUT); d++) if (m_act[d]) m += (1 << d);
    return m;
  endfunction

  // Replay with no concurrent writes: dirty destinations in ascending order.
  function automatic void model_commit();
    pulse_t p;
    int unsigned m = model_mask();
    exp_q.delete();
    for (int d = 0; d < int'(N_OUT); d++) begin
      if (m_dirty[d]) begin
        p.rise = 0; p.dest = d; p.src = m_src[d]; p.act = m; p.ok = 1'b1;
        exp_q.push_back(p);
        m_dirty[d] = 1'b0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input int unsigned d, input int unsigned s, input bit a, output bit exp_err);
    cfg_wr = 1'b1; cfg_dest = W_SEL'(d); cfg_src = W_SEL'(s); cfg_active = a;
    exp_err = model_write(d, s, a);
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic do_commit(output int unsigned c);
    c = cyc;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget, output bit seen, output int unsigned at);
    for (int unsigned n = 0; n < budget && !done; n++) tick();
    seen = done;
    at = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    n_checks++; if (update !== 1'b0) begin n_fail++; $display("FAIL reset_update: got %b want 0", update); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++; if (src_sel !== '0) begin n_fail++; $display("FAIL reset_src: got %h want 0", src_sel); end
    n_checks++; if (dest_sel !== '0) begin n_fail++; $display("FAIL reset_dest: got %h want 0", dest_sel); end
    n_checks++; if (act_mask !== '0) begin n_fail++; $display("FAIL reset_active: got %h want 0", act_mask); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_init_replay();
    int unsigned base, c, at;
    bit seen;
    base = plog.size();
    model_commit();
    do_commit(c);
    wait_done(200, seen, at);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL init_done_seen: got 0 want 1"); end
    n_checks++; if (at != c + 2 + PERIOD * exp_q.size()) begin
      n_fail++; $display("FAIL init_done_time: got %0d want %0d", at - c, 2 + PERIOD * exp_q.size()); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL init_busy_at_done: got %b want 0", busy); end
    n_checks++; if (plog.size() - base != exp_q.size()) begin
      n_fail++; $display("FAIL init_pulse_count: got %0d want %0d", plog.size() - base, exp_q.size()); end
    for (int k = 0; k < exp_q.size() && base + k < plog.size(); k++) begin
      pulse_t p = plog[base + k];
      pulse_t e = exp_q[k];
      n_checks++;
      if (p.dest != e.dest || p.src != e.src || p.act != e.act || !p.ok ||
          p.rise != c + 2 + T_S + PERIOD * k) begin
        n_fail++;
        $display("FAIL init_pulse%0d: got d=%0d s=%0d a=%h t=%0d ok=%b want d=%0d s=%0d a=%h t=%0d ok=1",
                 k, p.dest, p.src, p.act, p.rise - c, p.ok, e.dest, e.src, e.act, 2 + T_S + PERIOD * k);
      end
    end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL init_done_width: got %b want 0", done); end
  endtask

  task automatic test_single_write();
    int unsigned base, c, at;
    bit seen, e;
    do_write(3, 5, 1'b1, e);
    n_checks++; if (err !== e) begin n_fail++; $display("FAIL single_err: got %b want %b", err, e); end
    base = plog.size();
    model_commit();
    do_commit(c);
    wait_done(100, seen, at);
    n_checks++; if (!seen || at != c + 2 + PERIOD) begin
      n_fail++; $display("FAIL single_done: got seen=%b t=%0d want seen=1 t=%0d", seen, at - c, 2 + PERIOD); end
    n_checks++; if (plog.size() - base != 1) begin
      n_fail++; $display("FAIL single_count: got %0d want 1", plog.size() - base); end
    if (plog.size() > base) begin
      pulse_t p = plog[base];
      n_checks++;
      if (p.dest != 3 || p.src != 5 || p.act != 32'h08 || p.act != exp_q[0].act || !p.ok) begin
        n_fail++;
        $display("FAIL single_pulse: got d=%0d s=%0d a=%h ok=%b want d=3 s=5 a=08 ok=1", p.dest, p.src, p.act, p.ok);
      end
    end
    tick();
  endtask

  task automatic test_invalid_write();
    int unsigned base, c, at;
    bit seen, e;
    do_write(9, 1, 1'b1, e);
    n_checks++; if (err !== 1'b1 || e !== 1'b1) begin n_fail++; $display("FAIL bad_dest_err: got %b want 1", err); end
    tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL bad_dest_err_width: got %b want 0", err); end
    do_write(2, 8, 1'b0, e);
    n_checks++; if (err !== 1'b1 || e !== 1'b1) begin n_fail++; $display("FAIL bad_src_err: got %b want 1", err); end
    base = plog.size();
    model_commit();
    do_commit(c);
    wait_done(50, seen, at);
    n_checks++; if (!seen || at != c + 2) begin
      n_fail++; $display("FAIL empty_done: got seen=%b t=%0d want seen=1 t=2", seen, at - c); end
    n_checks++; if (plog.size() != base || exp_q.size() != 0) begin
      n_fail++; $display("FAIL empty_pulses: got %0d want 0", plog.size() - base); end
    tick();
  endtask

  task automatic test_rewrite_inflight();
    int unsigned base, c, at, m1;
    bit seen, e, hit;
    pulse_t p0, p1, p2, p4;
    do_write(1, 3, 1'b1, e);
    do_write(2, 4, 1'b0, e);
    do_write(4, 6, 1'b1, e);
    base = plog.size();
    model_commit();
    p0 = exp_q[0]; p1 = exp_q[1]; p4 = exp_q[2];
    do_commit(c);
    hit = 1'b0;
    for (int n = 0; n < 40 && !hit; n++) begin
      if (busy && dest_sel == W_SEL'(2)) hit = 1'b1;
      else tick();
    end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL inflight_reach_dest2: got 0 want 1"); end
    do_write(2, 7, 1'b1, e);
    m1 = model_mask();
    m_dirty[2] = 1'b0;
    p2.dest = 2; p2.src = 7; p2.act = m1; p2.ok = 1'b1; p2.rise = 0;
    p4.act = m1;
    exp_q = '{p0, p1, p2, p4};
    wait_done(200, seen, at);
    n_checks++; if (!seen || at != c + 2 + PERIOD * 4) begin
      n_fail++; $display("FAIL inflight_done: got seen=%b t=%0d want seen=1 t=%0d", seen, at - c, 2 + PERIOD * 4); end
    n_checks++; if (plog.size() - base != 4) begin
      n_fail++; $display("FAIL inflight_count: got %0d want 4", plog.size() - base); end
    for (int k = 0; k < 4 && base + k < plog.size(); k++) begin
      pulse_t p = plog[base + k];
      n_checks++;
      if (p.dest != exp_q[k].dest || p.src != exp_q[k].src || p.act != exp_q[k].act || !p.ok ||
          p.rise != c + 2 + T_S + PERIOD * k) begin
        n_fail++;
        $display("FAIL inflight_pulse%0d: got d=%0d s=%0d a=%h ok=%b want d=%0d s=%0d a=%h ok=1",
                 k, p.dest, p.src, p.act, p.ok, exp_q[k].dest, exp_q[k].src, exp_q[k].act);
      end
    end
    tick();
  endtask

  task automatic test_commit_while_busy();
    int unsigned base, c, at, dones;
    bit e;
    do_write(5, 1, 1'b1, e);
    do_write(6, 2, 1'b0, e);
    base = plog.size();
    model_commit();
    do_commit(c);
    dones = 0; at = 0;
    for (int n = 0; n < 60; n++) begin
      if (done) begin dones++; if (at == 0) at = cyc; end
      cfg_commit = (n == 5 || n == 12) ? 1'b1 : 1'b0;
      tick();
    end
    cfg_commit = 1'b0;
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL busy_commit_dones: got %0d want 1", dones); end
    n_checks++; if (at != c + 2 + PERIOD * 2) begin
      n_fail++; $display("FAIL busy_commit_time: got %0d want %0d", at - c, 2 + PERIOD * 2); end
    n_checks++; if (plog.size() - base != 2) begin
      n_fail++; $display("FAIL busy_commit_count: got %0d want 2", plog.size() - base); end
    for (int k = 0; k < 2 && base + k < plog.size(); k++) begin
      pulse_t p = plog[base + k];
      n_checks++;
      if (p.dest != exp_q[k].dest || p.src != exp_q[k].src || p.act != exp_q[k].act || !p.ok) begin
        n_fail++;
        $display("FAIL busy_commit_pulse%0d: got d=%0d s=%0d a=%h want d=%0d s=%0d a=%h",
                 k, p.dest, p.src, p.act, exp_q[k].dest, exp_q[k].src, exp_q[k].act);
      end
    end
  endtask

  task automatic test_rst_mid_pulse();
    int unsigned base, c, at;
    bit seen, e, hit;
    do_write(0, 3, 1'b1, e);
    do_write(7, 6, 1'b1, e);
    model_commit();
    do_commit(c);
    hit = 1'b0;
    for (int n = 0; n < 40 && !hit; n++) begin
      if (update) hit = 1'b1;
      else tick();
    end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL rst_reach_pulse: got 0 want 1"); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    n_checks++; if (update !== 1'b0) begin n_fail++; $display("FAIL rst_update: got %b want 0", update); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    base = plog.size();
    model_commit();
    do_commit(c);
    wait_done(200, seen, at);
    n_checks++; if (!seen || at != c + 2 + PERIOD * N_OUT) begin
      n_fail++; $display("FAIL rst_replay_done: got seen=%b t=%0d want seen=1 t=%0d", seen, at - c, 2 + PERIOD * N_OUT); end
    n_checks++; if (plog.size() - base != N_OUT) begin
      n_fail++; $display("FAIL rst_replay_count: got %0d want %0d", plog.size() - base, N_OUT); end
    for (int k = 0; k < exp_q.size() && base + k < plog.size(); k++) begin
      pulse_t p = plog[base + k];
      n_checks++;
      if (p.dest != exp_q[k].dest || p.src != exp_q[k].src || p.act != exp_q[k].act || !p.ok) begin
        n_fail++;
        $display("FAIL rst_replay_pulse%0d: got d=%0d s=%0d a=%h want d=%0d s=%0d a=%h",
                 k, p.dest, p.src, p.act, exp_q[k].dest, exp_q[k].src, exp_q[k].act);
      end
    end
    tick();
  endtask

  task automatic test_random();
    int unsigned base, c, at, nw, d, s;
    bit seen, e, a;
    for (int r = 0; r < 8; r++) begin
      nw = $urandom_range(1, 6);
      for (int w = 0; w < int'(nw); w++) begin
        d = $urandom_range(0, 9);
        s = $urandom_range(0, 9);
        a = 1'($urandom);
        do_write(d, s, a, e);
        n_checks++;
        if (err !== e) begin n_fail++; $display("FAIL rand%0d_err d=%0d s=%0d: got %b want %b", r, d, s, err, e); end
      end
      base = plog.size();
      model_commit();
      do_commit(c);
      wait_done(200, seen, at);
      n_checks++;
      if (!seen || at != c + 2 + PERIOD * exp_q.size() || plog.size() - base != exp_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_replay: got seen=%b t=%0d n=%0d want t=%0d n=%0d",
                 r, seen, at - c, plog.size() - base, 2 + PERIOD * exp_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && base + k < plog.size(); k++) begin
        pulse_t p = plog[base + k];
        n_checks++;
        if (p.dest != exp_q[k].dest || p.src != exp_q[k].src || p.act != exp_q[k].act || !p.ok ||
            p.rise != c + 2 + T_S + PERIOD * k) begin
          n_fail++;
          $display("FAIL rand%0d_pulse%0d: got d=%0d s=%0d a=%h ok=%b want d=%0d s=%0d a=%h",
                   r, k, p.dest, p.src, p.act, p.ok, exp_q[k].dest, exp_q[k].src, exp_q[k].act);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_init_replay();
    test_single_write();
    test_invalid_write();
    test_rewrite_inflight();
    test_commit_while_busy();
    test_rst_mid_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
